// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings and defaults for the data-memory arbiter
package dmem_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        OP_READ   = 2'b00,
        OP_WRITE  = 2'b01,
        OP_DELETE = 2'b10,
        OP_RSVD   = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10,
        ST_FLUSH  = 2'b11
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant; a tie goes to the port not granted last
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic accept,
    output logic grant0,
    output logic grant1
);

    logic last_grant;

    always_comb begin
        grant0 = req0;
        grant1 = req1;
        if (req0 && req1) begin
            grant0 = last_grant;
            grant1 = !last_grant;
        end
    end

    // Resets to port 1 so port 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= grant1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - serialises two requesters and a flush sweep onto the data memory
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [1:0]        req0_op,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [1:0]        req1_op,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    input  logic              flush_start,
    output logic              flush_busy,
    output logic              mem_delete,
    output logic              mem_state,
    output logic [DATA_W-1:0] mem_data_w,
    output logic [ADDR_W-1:0] mem_address,
    input  logic [DATA_W-1:0] mem_data_r
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            state;
    state_t            next_state;
    logic              lat_port;
    op_t               lat_op;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [ADDR_W-1:0] flush_cnt;
    logic              grant0;
    logic              grant1;
    logic              handshake;
    logic [DATA_W-1:0] access_rdata;

    assign handshake = req0_ready || req1_ready;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req0   (req0_valid),
        .req1   (req1_valid),
        .accept (handshake),
        .grant0 (grant0),
        .grant1 (grant1)
    );

    // Memory pins default to a harmless read of word 0 so nothing is written by accident.
    always_comb begin
        next_state  = state;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        flush_busy  = 1'b0;
        mem_delete  = 1'b0;
        mem_state   = 1'b1;
        mem_address = '0;
        mem_data_w  = '0;
        case (state)
            ST_IDLE: begin
                if (flush_start) begin
                    next_state = ST_FLUSH;
                end else if (grant0 || grant1) begin
                    req0_ready = grant0;
                    req1_ready = grant1;
                    next_state = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                mem_address = lat_addr;
                case (lat_op)
                    OP_WRITE: begin
                        mem_state  = 1'b0;
                        mem_data_w = lat_wdata;
                    end
                    OP_DELETE: mem_delete = 1'b1;
                    default: ;
                endcase
                next_state = ST_RESP;
            end
            ST_RESP: next_state = ST_IDLE;
            ST_FLUSH: begin
                flush_busy  = 1'b1;
                mem_delete  = 1'b1;
                mem_address = flush_cnt;
                if (flush_cnt == LAST) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    assign access_rdata = (lat_op == OP_WRITE || lat_op == OP_DELETE) ? '0 : mem_data_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            lat_port   <= 1'b0;
            lat_op     <= OP_READ;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            flush_cnt  <= '0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_rdata <= '0;
            rsp1_rdata <= '0;
        end else begin
            state      <= next_state;
            rsp0_valid <= (state == ST_RESP) && !lat_port;
            rsp1_valid <= (state == ST_RESP) && lat_port;
            if (handshake) begin
                lat_port  <= req1_ready;
                lat_op    <= op_t'(req1_ready ? req1_op : req0_op);
                lat_addr  <= req1_ready ? req1_addr : req0_addr;
                lat_wdata <= req1_ready ? req1_wdata : req0_wdata;
            end
            if (state == ST_ACCESS) begin
                if (lat_port) begin
                    rsp1_rdata <= access_rdata;
                end else begin
                    rsp0_rdata <= access_rdata;
                end
            end
            if (state == ST_FLUSH) begin
                flush_cnt <= (flush_cnt == LAST) ? '0 : flush_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized self-checking bench with a cycle-timeline reference model
module tb_dmem_arbiter;
    import dmem_pkg::*;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_valid, req0_ready, rsp0_valid;
    logic [1:0]    req0_op;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata, rsp0_rdata;
    logic          req1_valid, req1_ready, rsp1_valid;
    logic [1:0]    req1_op;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata, rsp1_rdata;
    logic          flush_start, flush_busy;
    logic          mem_delete, mem_state;
    logic [DW-1:0] mem_data_w, mem_data_r;
    logic [AW-1:0] mem_address;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .flush_start(flush_start), .flush_busy(flush_busy),
        .mem_delete(mem_delete), .mem_state(mem_state), .mem_data_w(mem_data_w),
        .mem_address(mem_address), .mem_data_r(mem_data_r)
    );

    always #5 clk = ~clk;

    // Environment memory driven only by the DUT pins.
    logic [DW-1:0] phys [DEPTH];
    assign mem_data_r = phys[mem_address];
    always @(posedge clk) begin
        if (mem_delete) phys[mem_address] <= '0;
        else if (!mem_state) phys[mem_address] <= mem_data_w;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // Requester intent and reference model state.
    bit            pend   [2];
    logic [1:0]    pop    [2];
    logic [AW-1:0] paddr  [2];
    logic [DW-1:0] pwdata [2];
    logic          fs = 1'b0;
    logic [DW-1:0] shadow [DEPTH];
    logic [DW-1:0] held   [2];
    int            rsp_at [2];
    int            cyc = 0;
    int            free_at, flush_from, acc_at, last;
    logic [1:0]    acc_op;
    logic [AW-1:0] acc_addr;
    logic [DW-1:0] acc_wdata;
    int            dut_grants [$];

    task automatic model_reset();
        free_at = 0; flush_from = -1000; acc_at = -1; last = 1;
        rsp_at[0] = -1; rsp_at[1] = -1; held[0] = '0; held[1] = '0;
    endtask

    task automatic drive_pins();
        req0_valid = pend[0]; req0_op = pop[0]; req0_addr = paddr[0]; req0_wdata = pwdata[0];
        req1_valid = pend[1]; req1_op = pop[1]; req1_addr = paddr[1]; req1_wdata = pwdata[1];
        flush_start = fs;
    endtask

    task automatic eval_cycle();
        int c = cyc;
        int g = -1;
        bit idle = (c >= free_at);
        bit in_flush = (c >= flush_from) && (c < flush_from + DEPTH);
        logic [1:0] op;
        logic [AW-1:0] a;
        if (idle && !fs) begin
            if (pend[0] && pend[1]) g = (last == 0) ? 1 : 0;
            else if (pend[0]) g = 0;
            else if (pend[1]) g = 1;
        end
        if (req0_ready) dut_grants.push_back(0);
        if (req1_ready) dut_grants.push_back(1);
        check("ready0", 32'(req0_ready), 32'(g == 0));
        check("ready1", 32'(req1_ready), 32'(g == 1));
        check("flush_busy", 32'(flush_busy), 32'(in_flush));
        check("rsp0_valid", 32'(rsp0_valid), 32'(rsp_at[0] == c));
        check("rsp1_valid", 32'(rsp1_valid), 32'(rsp_at[1] == c));
        if (rsp_at[0] <= c) check("rsp0_rdata", rsp0_rdata, held[0]);
        if (rsp_at[1] <= c) check("rsp1_rdata", rsp1_rdata, held[1]);
        if (in_flush) begin
            check("flush_delete", 32'(mem_delete), 32'd1);
            check("flush_state", 32'(mem_state), 32'd1);
            check("flush_addr", 32'(mem_address), 32'(c - flush_from));
        end else if (c == acc_at) begin
            check("acc_addr", 32'(mem_address), 32'(acc_addr));
            check("acc_state", 32'(mem_state), 32'(acc_op != OP_WRITE));
            check("acc_delete", 32'(mem_delete), 32'(acc_op == OP_DELETE));
            if (acc_op == OP_WRITE) check("acc_wdata", mem_data_w, acc_wdata);
        end else begin
            check("idle_state", 32'(mem_state), 32'd1);
            check("idle_delete", 32'(mem_delete), 32'd0);
        end
        if (in_flush) shadow[c - flush_from] = '0;
        if (idle && fs) begin
            flush_from = c + 1;
            free_at    = c + 1 + DEPTH;
        end else if (g >= 0) begin
            op = pop[g];
            a  = paddr[g];
            held[g] = (op == OP_WRITE || op == OP_DELETE) ? '0 : shadow[a];
            if (op == OP_WRITE) shadow[a] = pwdata[g];
            else if (op == OP_DELETE) shadow[a] = '0;
            rsp_at[g] = c + 3;
            acc_at    = c + 1;
            acc_op    = op;
            acc_addr  = a;
            acc_wdata = pwdata[g];
            last      = g;
            free_at   = c + 3;
            pend[g]   = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        drive_pins();
        @(negedge clk);
        eval_cycle();
    endtask

    task automatic do_reset();
        @(posedge clk);
        cyc++;
        #1;
        rst = 1'b1;
        pend[0] = 1'b0; pend[1] = 1'b0; fs = 1'b0;
        drive_pins();
        @(negedge clk);
        check("rst_ready0", 32'(req0_ready), 32'd0);
        check("rst_ready1", 32'(req1_ready), 32'd0);
        check("rst_busy", 32'(flush_busy), 32'd0);
        check("rst_rsp", 32'({rsp0_valid, rsp1_valid}), 32'd0);
        check("rst_rdata", rsp0_rdata | rsp1_rdata, 32'd0);
        check("rst_mem_state", 32'(mem_state), 32'd1);
        check("rst_mem_delete", 32'(mem_delete), 32'd0);
        check("rst_mem_addr", 32'(mem_address), 32'd0);
        check("rst_mem_data_w", mem_data_w, 32'd0);
        @(posedge clk);
        cyc++;
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic issue(input int p, input logic [1:0] op, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, output logic [DW-1:0] rd);
        int budget = 200;
        pend[p] = 1'b1; pop[p] = op; paddr[p] = a; pwdata[p] = wd;
        while (pend[p] && budget > 0) begin
            tick();
            budget--;
        end
        if (pend[p]) begin
            check("issue_timeout", 32'd0, 32'd1);
            pend[p] = 1'b0;
        end
        repeat (3) tick();
        check("issue_rsp_pulse", 32'(p == 0 ? rsp0_valid : rsp1_valid), 32'd1);
        rd = (p == 0) ? rsp0_rdata : rsp1_rdata;
    endtask

    task automatic compare_memory();
        for (int i = 0; i < DEPTH; i++) check("mem_word", phys[i], shadow[i]);
    endtask

    initial begin
        logic [DW-1:0] rd;
        int busy_cycles;
        int budget;
        for (int i = 0; i < DEPTH; i++) begin
            phys[i]   = $urandom;
            shadow[i] = phys[i];
        end
        for (int p = 0; p < 2; p++) begin
            pend[p] = 1'b0; pop[p] = 2'b00; paddr[p] = '0; pwdata[p] = '0;
        end
        drive_pins();
        model_reset();
        do_reset();

        issue(0, OP_WRITE, 5'd2, 32'hF000000F, rd);
        check("write_rdata", rd, 32'd0);
        issue(0, OP_READ, 5'd2, 32'd0, rd);
        check("read_back", rd, 32'hF000000F);

        issue(1, OP_DELETE, 5'd2, 32'd0, rd);
        check("delete_rdata", rd, 32'd0);
        issue(0, OP_READ, 5'd2, 32'd0, rd);
        check("read_deleted", rd, 32'd0);

        do_reset();
        dut_grants.delete();
        pop[0] = OP_READ; paddr[0] = 5'd1;
        pop[1] = OP_READ; paddr[1] = 5'd2;
        repeat (13) begin
            pend[0] = 1'b1;
            pend[1] = 1'b1;
            tick();
        end
        check("rr_count", 32'(dut_grants.size() >= 4), 32'd1);
        for (int i = 0; i < 4 && i < dut_grants.size(); i++)
            check("rr_order", 32'(dut_grants[i]), 32'(i % 2));
        pend[0] = 1'b0; pend[1] = 1'b0;
        repeat (4) tick();

        issue(0, OP_WRITE, 5'd0, 32'hA5A5A5A5, rd);
        issue(1, OP_WRITE, 5'd31, 32'hA5A5A5A5, rd);
        pend[0] = 1'b1; pop[0] = OP_READ; paddr[0] = 5'd0;
        fs = 1'b1;
        tick();
        fs = 1'b0;
        busy_cycles = 0;
        budget = 100;
        while (pend[0] && budget > 0) begin
            tick();
            if (flush_busy) busy_cycles++;
            budget--;
        end
        check("flush_wait_bound", 32'(pend[0]), 32'd0);
        check("flush_cycles", 32'(busy_cycles), 32'(DEPTH));
        repeat (3) tick();
        check("flush_read0", rsp0_rdata, 32'd0);
        issue(1, OP_READ, 5'd31, 32'd0, rd);
        check("flush_read31", rd, 32'd0);

        repeat (10) tick();
        compare_memory();

        for (int n = 0; n < 800; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 2) == 0) begin
                    pend[p]   = 1'b1;
                    pop[p]    = 2'($urandom_range(0, 3));
                    paddr[p]  = AW'($urandom_range(0, DEPTH - 1));
                    pwdata[p] = $urandom;
                end
            end
            fs = ($urandom_range(0, 199) == 0);
            tick();
        end
        fs = 1'b0;
        budget = 200;
        while ((pend[0] || pend[1]) && budget > 0) begin
            tick();
            budget--;
        end
        check("drain_bound", 32'({pend[0], pend[1]}), 32'd0);
        repeat (40) tick();
        compare_memory();

        issue(0, OP_WRITE, 5'd10, 32'h12345678, rd);
        fs = 1'b1;
        tick();
        fs = 1'b0;
        while (cyc < flush_from + 9) tick();
        @(posedge clk);
        cyc++;
        #1;
        rst = 1'b1;
        #1;
        check("midflush_busy", 32'(flush_busy), 32'd0);
        check("midflush_delete", 32'(mem_delete), 32'd0);
        check("midflush_rsp", 32'({rsp0_valid, rsp1_valid}), 32'd0);
        @(posedge clk);
        cyc++;
        #1;
        rst = 1'b0;
        model_reset();
        check("midflush_keep10", phys[10], 32'h12345678);
        compare_memory();
        fs = 1'b1;
        tick();
        fs = 1'b0;
        repeat (DEPTH + 4) tick();
        compare_memory();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester controller for the RV32I data memory (32 x 32-bit words, 5-bit address, Delete / State / data_w / address / data_r interface).
- Serialises read, write and delete accesses from port 0 (core load/store unit) and port 1 (debug/loader) using round-robin arbitration with a valid/ready handshake.
- Provides a flush sequencer that deletes every word in turn.
- Sits between the pipeline MEM stage and the data memory instance, and is the only driver of the memory control pins.

Parameters:
- ADDR_W, 5, memory word-address width
- DATA_W, 32, data width
- DEPTH, 32, number of words swept by flush (equal to 2**ADDR_W)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req0_valid  in  1  port 0 request present
- req0_ready  out  1  port 0 request accepted this cycle
- req0_op  in  2  00 read, 01 write, 10 delete, 11 treated as read
- req0_addr  in  ADDR_W  word address
- req0_wdata  in  DATA_W  write data
- rsp0_valid  out  1  one-cycle completion pulse
- rsp0_rdata  out  DATA_W  read data; 0 for write/delete
- req1_*, rsp1_*  same as port 0, for port 1
- flush_start  in  1  start a full-memory delete sweep
- flush_busy  out  1  sweep in progress
- mem_delete  out  1  to memory Delete
- mem_state  out  1  to memory State (0 write, 1 read)
- mem_data_w  out  DATA_W  to memory data_w
- mem_address  out  ADDR_W  to memory address
- mem_data_r  in  DATA_W  from memory data_r (combinational)

Behaviour:
- Reset values (asynchronous, active-high):
  - FSM = IDLE; last_grant = 1, so port 0 wins the first tie.
  - Flush counter = 0.
  - All rsp*_valid, req*_ready and flush_busy = 0; rdata registers = 0.
  - mem_delete = 0, mem_state = 1, mem_address = 0, mem_data_w = 0.
- Idle memory drive: mem_state = 1 and mem_delete = 0 in every state except a latched write or a delete/flush access. This rule guarantees no accidental write.
- FSM states: IDLE, ACCESS, RESP, FLUSH.
- IDLE:
  - If flush_start = 1: go to FLUSH. Flush has priority over requests, and both ready signals are 0 that cycle.
  - Otherwise arbitrate among valid requests. A single valid requester is granted. If both are valid, grant the port other than last_grant.
  - reqN_ready = 1 combinationally, in IDLE only, for the granted port.
  - On the handshake edge, latch op, addr, wdata and the port ID; update last_grant; go to ACCESS.
- ACCESS (one cycle):
  - mem_address = latched addr.
  - read: mem_state = 1.
  - write: mem_state = 0, mem_data_w = latched wdata.
  - delete: mem_delete = 1, mem_state = 1.
  - At the closing edge, capture mem_data_r for reads, or 0 otherwise, into the granted port's rdata register. Go to RESP.
- RESP (one cycle): rspN_valid = 1 for the latched port only; rspN_rdata holds its value until the next response on that port. Go to IDLE.
- Latency and throughput:
  - Handshake at edge k gives rsp_valid high during the cycle after edge k+2.
  - Maximum throughput is one access per 3 cycles.
  - Requesters must hold valid and payload stable until ready.
- FLUSH:
  - flush_busy = 1, mem_delete = 1, mem_address = counter.
  - Counter increments 0..DEPTH-1, one word per cycle.
  - After address DEPTH-1 the counter wraps to 0 and the FSM goes to IDLE. Flush takes exactly DEPTH cycles.
  - flush_start asserted while in FLUSH is ignored and does not restart the sweep.
  - Requests asserted during flush wait; ready stays 0.
- Reset mid-operation: any ACCESS, RESP or FLUSH is aborted immediately with no response pulse. The flush counter returns to 0.
- No back-pressure on responses: requesters must accept rsp_valid.

Decomposition:
- Shared package dmem_pkg holds:
  - op encodings: OP_READ=2'b00, OP_WRITE=2'b01, OP_DELETE=2'b10
  - FSM state encoding
  - ADDR_W / DATA_W defaults
- One natural sub-module: rr_arb2, a 2-way round-robin grant with last_grant state.

Test Plan:
- Single write then read: port 0 writes addr 5'b00010 with 32'hF000000F, then reads addr 2 -> rsp0_rdata = 32'hF000000F, three cycles after the read handshake.
- Delete: after the write above, port 1 deletes addr 2 and port 0 reads addr 2 -> rsp0_rdata = 32'h0; rsp1_valid pulses with rdata 0.
- Contention: both ports assert valid continuously with reads of addr 1 and addr 2 -> grants alternate 0,1,0,1; the first grant goes to port 0 after reset; no port is starved.
- Flush: write 32'hA5A5A5A5 to addr 0 and 31, then pulse flush_start -> flush_busy high for exactly 32 cycles, with mem_address sweeping 0..31 and mem_delete = 1. Reads of addr 0 and 31 return 0. A req0_valid held during flush gets ready only after flush_busy falls.
- Idle safety: no requests for 10 cycles -> mem_state = 1 and mem_delete = 0 throughout; memory contents are unchanged.
- Reset mid-flush: assert rst at sweep step 10 -> flush_busy = 0 immediately and no rsp pulses. A subsequent flush_start sweeps from address 0.
